conv_layer_sequencer: RTL and testbench

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

---
 rtl/conv_layer_sequencer_if.sv | 38 +++
 rtl/conv_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Bundle between the conv-layer sequencer, its upstream pixel source and the conv layer.
// The master modport is the environment side; the slave modport is the sequencer.
interface conv_layer_sequencer_if #(
  parameter int ch_in = 64,
  parameter int w_in  = 32,
  parameter int fold  = 1
);
  localparam int FL = (fold > 1) ? $clog2(fold) : 1;
  localparam int CW = $clog2(w_in);

  logic [ch_in-1:0] in_act;
  logic             in_valid;
  logic             in_ready;

  logic [ch_in-1:0] stream_act;
  logic             stream_act_en;
  logic [FL-1:0]    fold_add;
  logic             stream_maxpool_en;

  logic             out_valid;
  logic [CW-1:0]    out_row;
  logic [CW-1:0]    out_col;
  logic             frame_done;

  modport master (
    output in_act, in_valid,
    input  in_ready,
    input  stream_act, stream_act_en, fold_add, stream_maxpool_en,
    input  out_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  in_act, in_valid,
    output in_ready,
    output stream_act, stream_act_en, fold_add, stream_maxpool_en,
    output out_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Per-pixel sequencer for a folded conv layer: load, fold passes, drain, result strobe.
// Optional 2x2 maxpool sequencing is enabled by defining CONV_SEQ_MAXPOOL_EN.
module conv_layer_sequencer #(
  parameter int ch_in = 64,
  parameter int w_in  = 32,
  parameter int fold  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  conv_layer_sequencer_if.slave bus
);
  localparam int FL = (fold > 1) ? $clog2(fold) : 1;
  localparam int CW = $clog2(w_in);

  localparam logic [FL-1:0] FOLD_LAST = FL'(fold - 1);
  localparam logic [CW-1:0] EDGE      = CW'(w_in - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             armed;
  logic [FL-1:0]    fold_cnt;
  logic [CW-1:0]    row;
  logic [CW-1:0]    col;
  logic [ch_in-1:0] act_q;
  logic             out_valid_q;
  logic             frame_done_q;
  logic [CW-1:0]    out_row_q;
  logic [CW-1:0]    out_col_q;

  logic             accept;
  logic             drain_ok;
  logic             pool_hit;
  logic             frame_last;

  // Only pixels that close a 2x2 window produce a pooled result.
`ifdef CONV_SEQ_MAXPOOL_EN
  assign pool_hit = row[0] & col[0];
`else
  assign pool_hit = 1'b1;
`endif

  assign accept     = bus.in_valid && bus.in_ready;
  assign drain_ok   = (state == DRAIN) && !flush;
  assign frame_last = (row == EDGE) && (col == EDGE);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt             = state;
    bus.in_ready          = 1'b0;
    bus.stream_act_en     = 1'b0;
    bus.fold_add          = '0;
    bus.stream_maxpool_en = 1'b0;

    unique case (state)
      IDLE: begin
        bus.in_ready = armed && !flush;
        if (bus.in_valid && armed && !flush) state_nxt = LOAD;
      end
      LOAD: begin
        bus.stream_act_en = 1'b1;
        state_nxt         = FOLD;
      end
      FOLD: begin
        bus.fold_add = fold_cnt;
        if (fold_cnt == FOLD_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
`ifdef CONV_SEQ_MAXPOOL_EN
        bus.stream_maxpool_en = 1'b1;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (flush) state_nxt = IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Fold index counts only while in FOLD and is parked at 0 everywhere else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fold_cnt <= '0;
    end else if ((state == FOLD) && !flush && (fold_cnt != FOLD_LAST)) begin
      fold_cnt <= fold_cnt + 1'b1;
    end else begin
      fold_cnt <= '0;
    end
  end

  // Raster position of the pixel currently in flight; advances as DRAIN ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (flush) begin
      row <= '0;
      col <= '0;
    end else if (state == DRAIN) begin
      if (col == EDGE) begin
        col <= '0;
        row <= (row == EDGE) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // NOTE: the activation register is a single wide flop, not a memory, and its reset value is visible on stream_act.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q <= '0;
    end else if (accept) begin
      act_q <= bus.in_act;
    end
  end

  // Result strobe and coordinates are registered off DRAIN, so they appear one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= drain_ok && pool_hit;
      frame_done_q <= drain_ok && pool_hit && frame_last;
      if (drain_ok && pool_hit) begin
        out_row_q <= row;
        out_col_q <= col;
      end
    end
  end

  assign bus.stream_act = act_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;

  // Push and pool strobes come from distinct states and must never overlap.
  assert property (@(posedge clk) disable iff (!reset)
    !(bus.stream_act_en && bus.stream_maxpool_en));

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer against a cycle-offset reference model.
// Define CONV_SEQ_MAXPOOL_EN for both RTL and bench to exercise pooled sequencing.
module tb_conv_layer_sequencer;
  localparam int CH   = 16;
  localparam int W    = 4;
  localparam int FOLD = 4;
`ifdef CONV_SEQ_MAXPOOL_EN
  localparam bit POOL = 1'b1;
`else
  localparam bit POOL = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  conv_layer_sequencer_if #(.ch_in(CH), .w_in(W), .fold(FOLD)) bus ();

  conv_layer_sequencer #(.ch_in(CH), .w_in(W), .fold(FOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pixel accepted at cycle h shows its push at h+1, fold
  // index k at h+2+k, drain at h+FOLD+2 and its result at h+FOLD+3.
  int             cyc      = 0;
  bit             active   = 1'b0;
  int             hs_cyc   = 0;
  int             pix      = 0;
  int             txn_row  = 0;
  int             txn_col  = 0;
  bit             armed    = 1'b0;
  logic [CH-1:0]  act_ref  = '0;
  int             hs_total = 0;
  int             ov_seen  = 0;
  int             mp_seen  = 0;
  int             fd_seen  = 0;

  task automatic cycle(input logic v, input logic [CH-1:0] a, input logic f);
    int d;
    bit e_ready, e_en, e_mp, e_ov, e_fd, hs;
    int e_fold;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_act   = a;
    flush        = f;
    #1;
    d       = active ? (cyc - hs_cyc) : -1;
    e_ready = armed && !f && (!active || d >= FOLD + 3);
    e_en    = active && (d == 1);
    e_fold  = (active && d >= 2 && d <= FOLD + 1) ? d - 2 : 0;
    e_mp    = POOL && active && (d == FOLD + 2);
    e_ov    = active && (d == FOLD + 3) &&
              (!POOL || ((txn_row % 2 == 1) && (txn_col % 2 == 1)));
    e_fd    = e_ov && (txn_row == W - 1) && (txn_col == W - 1);

    check("in_ready", bus.in_ready, e_ready);
    check("stream_act", bus.stream_act, act_ref);
    check("stream_act_en", bus.stream_act_en, e_en);
    check("fold_add", bus.fold_add, e_fold);
    check("stream_maxpool_en", bus.stream_maxpool_en, e_mp);
    check("out_valid", bus.out_valid, e_ov);
    check("frame_done", bus.frame_done, e_fd);
    if (e_ov) begin
      check("out_row", bus.out_row, txn_row);
      check("out_col", bus.out_col, txn_col);
    end
    ov_seen += int'(bus.out_valid);
    mp_seen += int'(bus.stream_maxpool_en);
    fd_seen += int'(bus.frame_done);

    hs = e_ready && v;
    if (f) begin
      active = 1'b0;
      pix    = 0;
    end else begin
      if (active && d == FOLD + 2) pix = (pix + 1) % (W * W);
      if (active && d >= FOLD + 3) active = 1'b0;
      if (hs) begin
        active   = 1'b1;
        hs_cyc   = cyc;
        txn_row  = pix / W;
        txn_col  = pix % W;
        act_ref  = a;
        hs_total++;
      end
    end
    armed = 1'b1;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_stream_act"}, bus.stream_act, 0);
    check({tag, "_stream_act_en"}, bus.stream_act_en, 0);
    check({tag, "_fold_add"}, bus.fold_add, 0);
    check({tag, "_maxpool_en"}, bus.stream_maxpool_en, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_row"}, bus.out_row, 0);
    check({tag, "_out_col"}, bus.out_col, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  // Entered just after a cycle() sample; reset lands before the next rising edge.
  task automatic reset_pulse(input int delay_ns);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    #(delay_ns);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    reset   = 1'b1;
    active  = 1'b0;
    pix     = 0;
    act_ref = '0;
    armed   = 1'b1;
  endtask

  initial begin
    int start;
    bus.in_valid = 1'b0;
    bus.in_act   = '0;

    reset_pulse(1);

    // Single pixel: latency and fold index sequence.
    cycle(1'b1, CH'($urandom), 1'b0);
    repeat (FOLD + 5) cycle(1'b0, CH'($urandom), 1'b0);

    // Flush while fold_add shows 2 abandons the pixel and restarts the raster.
    cycle(1'b1, CH'($urandom), 1'b0);
    repeat (3) cycle(1'b0, CH'($urandom), 1'b0);
    cycle(1'b0, CH'($urandom), 1'b1);
    repeat (FOLD + 4) cycle(1'b0, CH'($urandom), 1'b0);
    cycle(1'b1, CH'($urandom), 1'b0);
    repeat (FOLD + 4) cycle(1'b0, CH'($urandom), 1'b0);

    // Full frame, back-to-back, in_act changing every cycle while not ready.
    cycle(1'b0, CH'($urandom), 1'b1);
    ov_seen = 0;
    mp_seen = 0;
    fd_seen = 0;
    start   = hs_total;
    for (int i = 0; i < 16 * (FOLD + 3) + 8 && hs_total < start + 16; i++)
      cycle(1'b1, CH'($urandom), 1'b0);
    repeat (FOLD + 4) cycle(1'b0, CH'($urandom), 1'b0);
    check("frame_pixels", hs_total - start, 16);
    check("frame_out_valid_count", ov_seen, POOL ? 4 : 16);
    check("frame_maxpool_count", mp_seen, POOL ? 16 : 0);
    check("frame_done_count", fd_seen, 1);

    // Reset during LOAD drops the pixel without a result.
    cycle(1'b1, CH'($urandom), 1'b0);
    cycle(1'b0, CH'($urandom), 1'b0);
    reset_pulse(1);
    ov_seen = 0;
    repeat (FOLD + 5) cycle(1'b0, CH'($urandom), 1'b0);
    check("reset_abandon_out_valid", ov_seen, 0);
    cycle(1'b1, CH'($urandom), 1'b0);
    repeat (FOLD + 4) cycle(1'b0, CH'($urandom), 1'b0);

    // Random traffic with sporadic flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), CH'($urandom), ($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 600) == 0) reset_pulse($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
